// File: rtl/interp_ctrl.sv
// Upsampling interpolation controller: reads N samples and writes (N-1)*L+1 samples in LIN, HOLD or ZERO mode.
// One write per cycle while emitting; each input segment costs L+2 cycles (fetch + read latency + L writes).
module interp_ctrl #(
  parameter int DATA_W  = 16,
  parameter int IN_AW   = 10,
  parameter int OUT_AW  = 10,
  parameter int LOG2_UP = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode_inc,
  input  logic                mode_dec,
  input  logic                sel,
  input  logic [IN_AW:0]      n_points,
  output logic                rd_en,
  output logic [IN_AW-1:0]    rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wr_en,
  output logic [OUT_AW-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [OUT_AW:0]     out_count
);

  localparam int L  = 1 << LOG2_UP;
  localparam int PW = DATA_W + 1 + LOG2_UP;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_WAIT_A, S_FETCH_B, S_WAIT_B, S_EMIT, S_FINAL, S_DONE
  } state_t;

  state_t                     state, state_nxt;
  logic [IN_AW:0]             n_reg;
  logic [IN_AW:0]             nm1;
  logic [IN_AW-1:0]           k;
  logic [LOG2_UP-1:0]         j;
  logic signed [DATA_W-1:0]   xa, xb;
  logic [31:0]                span;
  logic                       reject;
  logic                       last_seg;
  logic                       last_j;

  logic signed [DATA_W:0]     diff;
  logic signed [PW-1:0]       diff_x, j_x, xa_x, prod;
  logic [DATA_W-1:0]          lin;

  assign span     = (32'(n_points) - 32'd1) << LOG2_UP;
  assign reject   = (n_points < (IN_AW+1)'(2)) || (span > 32'((1 << OUT_AW) - 1));
  assign nm1      = n_reg - (IN_AW+1)'(1);
  assign last_seg = ((IN_AW+1)'(k) + (IN_AW+1)'(1)) == nm1;
  assign last_j   = (j == LOG2_UP'(L - 1));

  // Difference needs one extra bit; the floor shift keeps the result between xa and xb.
  assign diff   = $signed({xb[DATA_W-1], xb}) - $signed({xa[DATA_W-1], xa});
  assign diff_x = PW'(diff);
  assign j_x    = PW'({1'b0, j});
  assign xa_x   = PW'(xa);
  assign prod   = diff_x * j_x;
  assign lin    = DATA_W'(xa_x + (prod >>> LOG2_UP));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (sel) state_nxt = reject ? S_DONE : S_FETCH_A;
      end
      S_FETCH_A: begin
        rd_en     = 1'b1;
        state_nxt = S_WAIT_A;
      end
      S_WAIT_A:  state_nxt = S_FETCH_B;
      S_FETCH_B: begin
        rd_en     = 1'b1;
        rd_addr   = k + IN_AW'(1);
        state_nxt = S_WAIT_B;
      end
      S_WAIT_B:  state_nxt = S_EMIT;
      S_EMIT: begin
        wr_en   = 1'b1;
        wr_addr = OUT_AW'({k, j});
        case (mode)
          2'd0:    wr_data = lin;
          2'd2:    wr_data = (j == '0) ? xa : '0;
          default: wr_data = xa;
        endcase
        if (last_j) state_nxt = last_seg ? S_FINAL : S_FETCH_B;
      end
      S_FINAL: begin
        wr_en     = 1'b1;
        wr_addr   = OUT_AW'({nm1, LOG2_UP'(0)});
        wr_data   = xa;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (sel) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode      <= 2'd0;
      n_reg     <= '0;
      k         <= '0;
      j         <= '0;
      xa        <= '0;
      xb        <= '0;
      err       <= 1'b0;
      out_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sel) begin
            n_reg     <= n_points;
            k         <= '0;
            err       <= reject;
            out_count <= '0;
          end else if (mode_inc && !mode_dec) begin
            mode <= (mode == 2'd2) ? 2'd0 : mode + 2'd1;
          end else if (mode_dec && !mode_inc) begin
            mode <= (mode == 2'd0) ? 2'd2 : mode - 2'd1;
          end
        end
        S_WAIT_A: xa <= rd_data;
        S_WAIT_B: begin
          xb <= rd_data;
          j  <= '0;
        end
        S_EMIT: begin
          j <= j + LOG2_UP'(1);
          if (last_j) begin
            xa <= xb;
            k  <= k + IN_AW'(1);
          end
        end
        S_FINAL: out_count <= (OUT_AW+1)'({nm1, LOG2_UP'(0)}) + (OUT_AW+1)'(1);
        S_DONE: if (sel) err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interp_ctrl.sv
// Randomised bench for interp_ctrl with a sample-level reference model and memory models.
module tb_interp_ctrl;
  localparam int DATA_W = 16, IN_AW = 10, OUT_AW = 10, LOG2_UP = 2;
  localparam int L = 1 << LOG2_UP;

  logic                clk = 1'b0;
  logic                reset, mode_inc, mode_dec, sel;
  logic [IN_AW:0]      n_points;
  logic                rd_en, wr_en, busy, done, err;
  logic [IN_AW-1:0]    rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [OUT_AW-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [1:0]          mode;
  logic [OUT_AW:0]     out_count;

  interp_ctrl #(.DATA_W(DATA_W), .IN_AW(IN_AW), .OUT_AW(OUT_AW), .LOG2_UP(LOG2_UP)) dut (
    .clk(clk), .reset(reset), .mode_inc(mode_inc), .mode_dec(mode_dec), .sel(sel),
    .n_points(n_points), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mode(mode), .busy(busy),
    .done(done), .err(err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mode_m = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic signed [DATA_W-1:0] in_mem [0:(1<<IN_AW)-1];
  typedef struct { int addr; int data; } wr_t;
  wr_t wlog[$];
  int  rd_cnt;

  // Input memory answers one cycle after the strobe; garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? in_mem[rd_addr] : DATA_W'($urandom);

  always @(posedge clk) begin
    if (reset) begin
      if (wr_en) begin
        wr_t w;
        w.addr = int'(wr_addr);
        w.data = int'($signed(wr_data));
        wlog.push_back(w);
      end
      if (rd_en) rd_cnt++;
    end
  end

  function automatic int exp_sample(input int m, input int n, input int a);
    int seg = a / L;
    int jj  = a % L;
    int xa, xb, p, q;
    if (seg == n - 1) return int'(in_mem[n-1]);
    xa = int'(in_mem[seg]);
    xb = int'(in_mem[seg+1]);
    if (m == 1) return xa;
    if (m == 2) return (jj == 0) ? xa : 0;
    p = (xb - xa) * jj;
    q = p / L;
    if (p < 0 && (p % L) != 0) q = q - 1;
    return xa + q;
  endfunction

  task automatic pulse_mode(input bit inc, input bit dec);
    mode_inc = inc; mode_dec = dec;
    @(negedge clk);
    mode_inc = 0; mode_dec = 0;
    if (inc && !dec) mode_m = (mode_m + 1) % 3;
    else if (dec && !inc) mode_m = (mode_m + 2) % 3;
    check("mode_sel", mode, mode_m);
  endtask

  task automatic run(input int n, input bit with_inc);
    bit rej = (n < 2) || ((n - 1) * L > (1 << OUT_AW) - 1);
    int nw  = rej ? 0 : (n - 1) * L + 1;
    int cyc;
    wlog.delete();
    rd_cnt = 0;
    n_points = (IN_AW+1)'(n);
    sel = 1; mode_inc = with_inc;
    @(negedge clk);
    sel = 0; mode_inc = 0;
    cyc = 1;
    check("busy_start", busy, !rej);
    check("mode_sel_prio", mode, mode_m);
    while (!done && cyc < 8000) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, rej ? 1 : 4 + (n - 1) * (L + 2));
    check("err", err, rej);
    check("out_count", out_count, nw);
    check("n_writes", wlog.size(), nw);
    check("n_reads", rd_cnt, rej ? 0 : n);
    for (int i = 0; i < wlog.size() && i < nw; i++) begin
      check("wr_addr", wlog[i].addr, i);
      check("wr_data", wlog[i].data, exp_sample(mode_m, n, i));
    end
    mode_inc = 1;
    @(negedge clk);
    mode_inc = 0; mode_dec = 1;
    @(negedge clk);
    mode_dec = 0;
    check("hold_mode", mode, mode_m);
    check("hold_done", done, 1);
    check("hold_err", err, rej);
    sel = 1;
    @(negedge clk);
    sel = 0;
    check("ack_done", done, 0);
    check("ack_err", err, 0);
  endtask

  task automatic load2(input int a, input int b);
    in_mem[0] = DATA_W'(a);
    in_mem[1] = DATA_W'(b);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) in_mem[i] = DATA_W'($urandom);
  endtask

  initial begin
    bit seen;
    reset = 0; mode_inc = 0; mode_dec = 0; sel = 0; n_points = '0;
    repeat (2) @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out_count", out_count, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    reset = 1;
    @(negedge clk);

    pulse_mode(0, 1);
    pulse_mode(1, 0);
    pulse_mode(1, 0);
    pulse_mode(1, 1);
    pulse_mode(1, 0);
    pulse_mode(1, 0);

    in_mem[0] = 16'sd0; in_mem[1] = 16'sd8; in_mem[2] = -16'sd8;
    run(3, 0);
    load2(0, 3);          run(2, 0);
    load2(0, -3);         run(2, 0);
    load2(-32768, 32767); run(2, 0);
    load2(32767, -32768); run(2, 0);
    pulse_mode(1, 0);
    load2(5, 9);          run(2, 0);
    pulse_mode(1, 0);
    run(2, 0);

    run(1, 1);
    run(0, 0);
    run(257, 0);
    load_random(256);
    run(256, 0);
    run(1024, 0);

    for (int it = 0; it < 12; it++) begin
      int np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) pulse_mode(1'($urandom), 1'($urandom));
      begin
        int n = $urandom_range(2, 24);
        load_random(n);
        run(n, 1'($urandom));
      end
    end

    load_random(3);
    n_points = (IN_AW+1)'(3);
    sel = 1;
    @(negedge clk);
    sel = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (wr_en && wr_addr == OUT_AW'(2)) seen = 1;
      else @(negedge clk);
    end
    check("mid_reset_reached", seen, 1);
    reset = 0;
    @(negedge clk);
    check("mid_reset_wr_en", wr_en, 0);
    check("mid_reset_rd_en", rd_en, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_mode", mode, 0);
    reset = 1;
    mode_m = 0;
    @(negedge clk);
    load_random(4);
    run(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
